camera_byte_capture: RTL and testbench

Front-end capture stage for the OV5640 parallel port. It synchronizes the raw camera pins (PCLK, HREF, VSYNC, D[7:0]) into the single `clk_in` domain and detects PCLK rising edges. It emits one `valid_byte_out` strobe per camera byte, together with registered sync levels and running `hcount`/`vcount`. It also pairs bytes into 16-bit pixels. Its outputs feed the hcount/vcount, cycle-count, frame-length and rowlen/fps display blocks directly, and feed the downstream pixel consumer.

---
 rtl/camera_byte_capture.sv | 188 ++++++++++++++++++
 tb/tb_camera_byte_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/camera_byte_capture.sv
// camera_byte_capture
// Brings the OV5640 parallel-port pins into the clk_in domain, turns each
// PCLK rising edge into a one-cycle byte strobe, and derives the sync levels,
// row/frame counters, 16-bit pixel pairs and a frame-done pulse from the
// captured bytes. All outputs are registered and change only on a byte event.
module camera_byte_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        cam_pclk_in,
    input  logic        cam_hsync_in,
    input  logic        cam_vsync_in,
    input  logic [7:0]  cam_data_in,
    output logic        valid_byte_out,
    output logic [7:0]  data_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [12:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic [15:0] pixel_out,
    output logic        pixel_valid_out,
    output logic        frame_done_out
);

    // Synchronizer chains; equal depth keeps data aligned with its PCLK edge.
    logic [SYNC_STAGES-1:0]       pclk_sync_q;
    logic [SYNC_STAGES-1:0]       href_sync_q;
    logic [SYNC_STAGES-1:0]       vsync_sync_q;
    logic [SYNC_STAGES-1:0][7:0]  data_sync_q;
    logic                         pclk_prev_q;

    logic       pclk_s, href_s, vsync_s;
    logic [7:0] data_s;

    // Capture state. hsync_q doubles as the previous HREF sample and vsync_q
    // as the previous VSYNC sample: both are exactly "level at last strobe".
    logic        valid_q,       valid_d;
    logic [7:0]  data_q,        data_d;
    logic        hsync_q,       hsync_d;
    logic        vsync_q,       vsync_d;
    logic [12:0] hcount_q,      hcount_d;
    logic [11:0] vcount_q,      vcount_d;
    logic [15:0] pixel_q,       pixel_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        frame_done_q,  frame_done_d;
    logic [7:0]  hi_byte_q,     hi_byte_d;
    logic        phase_q,       phase_d;
    logic        new_frame_q,   new_frame_d;
    // Set once HREF has been seen low at a byte event since reset, so a row
    // already in progress at reset release is ignored until the next row.
    logic        armed_q,       armed_d;

    logic byte_evt;
    logic href_rise, href_hold, href_fall;
    logic vsync_rise, vsync_fall;

    assign pclk_s  = pclk_sync_q[SYNC_STAGES-1];
    assign href_s  = href_sync_q[SYNC_STAGES-1];
    assign vsync_s = vsync_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];

    assign byte_evt   = pclk_s & ~pclk_prev_q;
    assign href_rise  = byte_evt & armed_q &  href_s & ~hsync_q;
    assign href_hold  = byte_evt & armed_q &  href_s &  hsync_q;
    assign href_fall  = byte_evt & armed_q & ~href_s &  hsync_q;
    assign vsync_rise = byte_evt &  vsync_s & ~vsync_q;
    assign vsync_fall = byte_evt & ~vsync_s &  vsync_q;

    // Shift camera pins through the synchronizers and keep the delayed PCLK.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pclk_sync_q  <= '1;
            href_sync_q  <= '0;
            vsync_sync_q <= '0;
            data_sync_q  <= '0;
            pclk_prev_q  <= 1'b1;
        end else begin
            pclk_sync_q  <= {pclk_sync_q[SYNC_STAGES-2:0], cam_pclk_in};
            href_sync_q  <= {href_sync_q[SYNC_STAGES-2:0], cam_hsync_in};
            vsync_sync_q <= {vsync_sync_q[SYNC_STAGES-2:0], cam_vsync_in};
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], cam_data_in};
            pclk_prev_q  <= pclk_s;
        end
    end

    // Next-state for everything derived from a byte event.
    // NOTE: every _d gets its hold value first, so no path leaves a signal
    // unassigned and no latch is inferred.
    always_comb begin
        valid_d       = byte_evt;
        data_d        = data_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = vsync_rise;
        hi_byte_d     = hi_byte_q;
        phase_d       = phase_q;
        new_frame_d   = new_frame_q;
        armed_d       = armed_q | (byte_evt & ~href_s);

        if (byte_evt) begin
            data_d  = data_s;
            hsync_d = href_s;
            vsync_d = vsync_s;
        end

        // Row length: load on row start, count saturating while HREF stays high.
        if (href_rise) begin
            hcount_d = 13'd1;
        end else if (href_hold && (hcount_q != '1)) begin
            hcount_d = hcount_q + 13'd1;
        end

        // Rows per frame: count row ends; the first row after VSYNC restarts it.
        if (href_fall && (vcount_q != '1)) begin
            vcount_d = vcount_q + 12'd1;
        end
        if (href_rise && new_frame_q) begin
            vcount_d    = 12'd0;
            new_frame_d = 1'b0;
        end
        if (vsync_fall) begin
            new_frame_d = 1'b1;
        end

        // Pixel pairing: a row start always begins at phase 0.
        if (href_rise || href_hold) begin
            if (href_rise || !phase_q) begin
                hi_byte_d = data_s;
                phase_d   = 1'b1;
            end else begin
                pixel_d       = {hi_byte_q, data_s};
                pixel_valid_d = 1'b1;
                phase_d       = 1'b0;
            end
        end
    end

    // Capture registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q       <= 1'b0;
            data_q        <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            hi_byte_q     <= '0;
            phase_q       <= 1'b0;
            new_frame_q   <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            data_q        <= data_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            hi_byte_q     <= hi_byte_d;
            phase_q       <= phase_d;
            new_frame_q   <= new_frame_d;
            armed_q       <= armed_d;
        end
    end

    assign valid_byte_out  = valid_q;
    assign data_out        = data_q;
    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign pixel_out       = pixel_q;
    assign pixel_valid_out = pixel_valid_q;
    assign frame_done_out  = frame_done_q;

endmodule

// File: tb/tb_camera_byte_capture.sv
// Testbench for camera_byte_capture: drives a PCLK/HREF/VSYNC/data stream
// built from rows and frames, and checks every strobe and counter against a
// row/frame-level model of the capture rules.
module tb_camera_byte_capture;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        cam_pclk_in = 1'b1;
    logic        cam_hsync_in = 1'b0;
    logic        cam_vsync_in = 1'b0;
    logic [7:0]  cam_data_in = 8'h00;
    logic        valid_byte_out;
    logic [7:0]  data_out;
    logic        hsync_out;
    logic        vsync_out;
    logic [12:0] hcount_out;
    logic [11:0] vcount_out;
    logic [15:0] pixel_out;
    logic        pixel_valid_out;
    logic        frame_done_out;

    int tests_run = 0;
    int tests_failed = 0;

    // Row/frame-level model state.
    int m_hcount = 0;     // length of the current/last row, saturated
    int m_vcount = 0;     // rows ended in the current/last frame, saturated
    bit m_new_frame = 0;  // a VSYNC pulse ended since the last row start
    bit m_row_open = 0;   // a row's bytes were sent without its end byte

    camera_byte_capture #(.SYNC_STAGES(2)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .cam_pclk_in     (cam_pclk_in),
        .cam_hsync_in    (cam_hsync_in),
        .cam_vsync_in    (cam_vsync_in),
        .cam_data_in     (cam_data_in),
        .valid_byte_out  (valid_byte_out),
        .data_out        (data_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .hcount_out      (hcount_out),
        .vcount_out      (vcount_out),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .frame_done_out  (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_byte_out), 0);
        check({tag, "_data"}, 32'(data_out), 0);
        check({tag, "_hsync"}, 32'(hsync_out), 0);
        check({tag, "_vsync"}, 32'(vsync_out), 0);
        check({tag, "_hcount"}, 32'(hcount_out), 0);
        check({tag, "_vcount"}, 32'(vcount_out), 0);
        check({tag, "_pixel"}, 32'(pixel_out), 0);
        check({tag, "_pvalid"}, 32'(pixel_valid_out), 0);
        check({tag, "_fdone"}, 32'(frame_done_out), 0);
    endtask

    // One camera byte: PCLK high for `half` cycles then low for `half`.
    // Called at a negedge with PCLK already low. The strobe must appear on
    // the sample after the 2nd edge following the PCLK-high sample (k==2),
    // and nowhere else in the byte window.
    task automatic send_byte(input logic href, input logic vs, input logic [7:0] d,
                             input int half, input logic exp_pv, input logic [15:0] exp_px,
                             input logic exp_fd, input int exp_h, input int exp_v);
        cam_hsync_in = href;
        cam_vsync_in = vs;
        cam_data_in  = d;
        cam_pclk_in  = 1'b1;
        for (int k = 0; k < 2 * half; k++) begin
            @(negedge clk_in);
            if (k == 2) begin
                check("valid_strobe", 32'(valid_byte_out), 1);
                check("data", 32'(data_out), 32'(d));
                check("hsync", 32'(hsync_out), 32'(href));
                check("vsync", 32'(vsync_out), 32'(vs));
                check("hcount", 32'(hcount_out), 32'(exp_h));
                check("vcount", 32'(vcount_out), 32'(exp_v));
                check("pixel_valid", 32'(pixel_valid_out), 32'(exp_pv));
                check("frame_done", 32'(frame_done_out), 32'(exp_fd));
                if (exp_pv) check("pixel", 32'(pixel_out), 32'(exp_px));
            end else begin
                check("valid_width", 32'(valid_byte_out), 0);
                check("pixel_valid_width", 32'(pixel_valid_out), 0);
                check("frame_done_width", 32'(frame_done_out), 0);
            end
            if (k == half - 1) cam_pclk_in = 1'b0;
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Row end byte (HREF low): the row is counted, its length is held.
    task automatic end_row(input int half);
        m_vcount = sat(m_vcount + 1, 4095);
        m_row_open = 0;
        send_byte(1'b0, 1'b0, 8'($urandom), half, 1'b0, 16'h0, 1'b0, m_hcount, m_vcount);
    endtask

    // A row of n HREF-high bytes; fixed data uses 0x11, 0x22, ...
    task automatic send_row(input int n, input int half, input bit fixed, input bit terminate);
        logic [7:0] b;
        logic [7:0] prev_b;
        prev_b = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = fixed ? 8'((i + 1) * 17) : 8'($urandom);
            if (i == 0 && m_new_frame) begin
                m_vcount = 0;
                m_new_frame = 0;
            end
            m_hcount = sat(i + 1, 8191);
            send_byte(1'b1, 1'b0, b, half, (i % 2) == 1, {prev_b, b}, 1'b0, m_hcount, m_vcount);
            prev_b = b;
        end
        m_row_open = 1;
        if (terminate) end_row(half);
    endtask

    // VSYNC high for len bytes, then one byte with VSYNC low.
    task automatic vsync_pulse(input int len);
        for (int j = 0; j < len; j++) begin
            if (j == 0 && m_row_open) begin
                m_vcount = sat(m_vcount + 1, 4095);
                m_row_open = 0;
            end
            send_byte(1'b0, 1'b1, 8'($urandom), 4, 1'b0, 16'h0, j == 0, m_hcount, m_vcount);
        end
        m_new_frame = 1;
        send_byte(1'b0, 1'b0, 8'($urandom), 4, 1'b0, 16'h0, 1'b0, m_hcount, m_vcount);
    endtask

    task automatic idle_byte(input int half);
        send_byte(1'b0, 1'b0, 8'($urandom), half, 1'b0, 16'h0, 1'b0, m_hcount, m_vcount);
    endtask

    initial begin
        // Reset with PCLK held high through release.
        #2 rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_all_zero("in_reset");
        rst_n_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            check("no_strobe_pclk_high", 32'(valid_byte_out), 0);
        end
        cam_pclk_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("no_strobe_pclk_low", 32'(valid_byte_out), 0);
        end

        // Blanking byte, then the fixed 6-byte row (0x1122, 0x3344, 0x5566).
        idle_byte(4);
        send_row(6, 4, 1'b1, 1'b1);
        check("single_row_hcount", 32'(hcount_out), 6);
        check("single_row_vcount", 32'(vcount_out), 1);

        // Odd row drops its last byte; the next row starts at phase 0.
        send_row(5, 4, 1'b0, 1'b1);
        check("odd_row_hcount", 32'(hcount_out), 5);
        send_row(4, 4, 1'b0, 1'b1);
        idle_byte(4);

        // Frame: VSYNC, 3 rows of 4 bytes, VSYNC (count held), next row clears.
        vsync_pulse(3);
        for (int r = 0; r < 3; r++) begin
            send_row(4, 4, 1'b0, 1'b1);
            idle_byte(4);
        end
        check("frame_vcount", 32'(vcount_out), 3);
        vsync_pulse(2);
        check("frame_vcount_held", 32'(vcount_out), 3);
        send_row(4, 4, 1'b0, 1'b1);
        check("frame_vcount_restart", 32'(vcount_out), 1);

        // Row end coincides with VSYNC rising.
        send_row(4, 4, 1'b0, 1'b0);
        vsync_pulse(2);

        // Randomised rows with random PCLK rates (clk_in >= 4x PCLK).
        for (int r = 0; r < 6; r++) begin
            send_row($urandom_range(1, 24), $urandom_range(2, 4), 1'b0, 1'b1);
            idle_byte(2);
            if ($urandom_range(0, 2) == 0) vsync_pulse($urandom_range(1, 3));
        end

        // Row longer than the counter range.
        send_row(9000, 2, 1'b0, 1'b1);
        check("sat_hcount", 32'(hcount_out), 8191);

        // Reset in the middle of a row.
        idle_byte(4);
        send_row(3, 4, 1'b0, 1'b0);
        #2 rst_n_in = 1'b0;
        #1 check_all_zero("async_reset");
        m_hcount = 0;
        m_vcount = 0;
        m_new_frame = 0;
        m_row_open = 0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b1, 1'b0, 8'($urandom), 4, 1'b0, 16'h0, 1'b0, 0, 0);
        end
        idle_byte(4);
        send_row(4, 4, 1'b0, 1'b1);
        check("post_reset_hcount", 32'(hcount_out), 4);
        check("post_reset_vcount", 32'(vcount_out), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete, %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

endmodule
